logic_sequencer: RTL

//  Command sequencer for the 8-bit logic unit (logic_controller, opcodes 1..7).

---
 rtl/logic_sequencer_if.sv | 48 ++++
 rtl/logic_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_sequencer_if.sv
// Signal bundle between a requester, logic_sequencer and the combinational logic unit.
// Latency: none, plain nets.
// Backpressure: cmd_valid/cmd_ready on commands, res_valid/res_ready on results.
interface logic_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
);
    // Command channel (requester -> sequencer)
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [7:0]                 cmd_opcode;
    logic [WIDTH-1:0]           cmd_a;
    logic [WIDTH-1:0]           cmd_b;
    logic                       cmd_use_acc;

    // Logic unit drive and its combinational answer
    logic [7:0]                 lu_opcode;
    logic [WIDTH-1:0]           lu_a;
    logic [WIDTH-1:0]           lu_b;
    logic [WIDTH-1:0]           lu_y;

    // Response channel (sequencer -> requester)
    logic                       res_valid;
    logic                       res_ready;
    logic [WIDTH-1:0]           res_data;
    logic                       res_err;

    // Status
    logic [WIDTH-1:0]           acc_out;
    logic                       busy;
    logic [$clog2(DEPTH+1)-1:0] count;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc,
        input  lu_y, res_ready,
        output cmd_ready, lu_opcode, lu_a, lu_b,
        output res_valid, res_data, res_err, acc_out, busy, count
    );

    // Requester / logic-unit side
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_use_acc,
        output lu_y, res_ready,
        input  cmd_ready, lu_opcode, lu_a, lu_b,
        input  res_valid, res_data, res_err, acc_out, busy, count
    );
endinterface

// File: rtl/logic_sequencer.sv
// Generic synchronous FIFO used to queue sequencer commands.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: push_rdy drops when full unless a pop happens the same cycle.
module seq_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    output logic          push_rdy,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count
);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          full, empty, push, pop;

    // Full/empty come from the occupancy counter, so pointers may simply wrap.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = pop_rdy && !empty;
    // At full, a same-cycle pop frees the slot the push is about to take.
    assign push_rdy = !full || pop;
    assign push     = push_vld && push_rdy;
    assign pop_vld  = !empty;
    assign pop_dat  = mem_q[rd_ptr_q];
    assign count    = count_q;

    // Next pointer/occupancy/storage values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// Command sequencer feeding one queued command at a time to the 8-bit logic unit.
// Latency: IDLE pop, one EXEC cycle, then RESP; result valid 3 cycles after the accept cycle.
// Backpressure: cmd_ready = FIFO has room; a stalled RESP stops popping but the FIFO keeps filling.
module logic_sequencer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    logic_sequencer_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             use_acc;
        logic [7:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       lu_op_q, lu_op_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d;
    logic [WIDTH-1:0] lu_b_q, lu_b_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_err_q, res_err_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    cmd_t             cmd_in;
    cmd_t             head;
    logic             head_vld;
    logic             pop_rdy;
    logic             op_ok;
    logic [CW-1:0]    fifo_count;

    assign cmd_in = '{use_acc: bus.cmd_use_acc,
                      opcode:  bus.cmd_opcode,
                      a:       bus.cmd_a,
                      b:       bus.cmd_b};

    // Pop only depends on FSM state, so cmd_ready never depends on cmd_valid.
    assign pop_rdy = (state_q == IDLE);

    seq_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (bus.cmd_valid),
        .push_dat (cmd_in),
        .push_rdy (bus.cmd_ready),
        .pop_vld  (head_vld),
        .pop_rdy  (pop_rdy),
        .pop_dat  (head),
        .count    (fifo_count)
    );

    // The logic unit only defines opcodes 1..7; anything else is reported as an error.
    assign op_ok = (lu_op_q >= 8'd1) && (lu_op_q <= 8'd7);

    // Next-state and datapath decisions for IDLE -> EXEC -> RESP
    always_comb begin
        state_d    = state_q;
        lu_op_d    = lu_op_q;
        lu_a_d     = lu_a_q;
        lu_b_d     = lu_b_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        acc_d      = acc_q;
        case (state_q)
            IDLE: begin
                if (head_vld) begin
                    // Operand registers double as the lu_* outputs and hold outside EXEC.
                    lu_op_d = head.opcode;
                    lu_a_d  = head.use_acc ? acc_q : head.a;
                    lu_b_d  = head.b;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_ok) begin
                    res_data_d = bus.lu_y;
                    acc_d      = bus.lu_y;
                    res_err_d  = 1'b0;
                end else begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, result and accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lu_op_q    <= '0;
            lu_a_q     <= '0;
            lu_b_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            lu_op_q    <= lu_op_d;
            lu_a_q     <= lu_a_d;
            lu_b_q     <= lu_b_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.lu_opcode = lu_op_q;
    assign bus.lu_a      = lu_a_q;
    assign bus.lu_b      = lu_b_q;
    assign bus.res_valid = (state_q == RESP);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign bus.acc_out   = acc_q;
    assign bus.busy      = (state_q != IDLE) || head_vld;
    assign bus.count     = fifo_count;
endmodule
